// File: rtl/wb_spimaster_if.sv
// Wishbone single-transfer bus between the host fabric and the SPI master.
interface wb_spimaster_if;
  logic [14:0] wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_spimaster.sv
// Turns one WB single read/write into one 32-bit SPI frame to a channel FPGA (stone).
// Optional WSPI_POSTED_WRITE_EN: writes are acked right after latching and the frame runs on its own.
module wb_spimaster #(
  parameter int unsigned CLKDIV   = 4,
  parameter int unsigned TURN_GAP = 112
) (
  input  logic          CLK,
  input  logic          RST_N,
  output logic          SPICLK,
  inout  wire           SPIDAT,
  output logic          SPIFR,
  wb_spimaster_if.slave wb
);
  localparam int unsigned HW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int unsigned GW = (TURN_GAP > 1) ? $clog2(TURN_GAP) : 1;
  localparam logic [HW-1:0] HALF_END = HW'(CLKDIV - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(TURN_GAP - 1);
`ifdef WSPI_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_CMD, S_TURN, S_RDATA, S_WDATA, S_END, S_ACK, S_RECOVER
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [4:0]    bit_q, bit_d;
  logic [31:0]   sr_q, sr_d;
  logic [15:0]   rd_q, rd_d;
  logic [15:0]   dat_o_q, dat_o_d;
  logic          we_q, we_d;
  logic          abort_q, abort_d;
  logic          spiclk_q, spiclk_d;
  logic          spifr_q, spifr_d;
  logic          oe_q, oe_d;
  logic          ack_q, ack_d;
  logic          sdi_q;

  assign SPICLK      = spiclk_q;
  assign SPIFR       = spifr_q;
  assign SPIDAT      = oe_q ? sr_q[31] : 1'bz;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_o_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      half_q   <= '0;
      gap_q    <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
      rd_q     <= '0;
      dat_o_q  <= '0;
      we_q     <= 1'b0;
      abort_q  <= 1'b0;
      spiclk_q <= 1'b1;
      spifr_q  <= 1'b1;
      oe_q     <= 1'b0;
      ack_q    <= 1'b0;
      sdi_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      gap_q    <= gap_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
      rd_q     <= rd_d;
      dat_o_q  <= dat_o_d;
      we_q     <= we_d;
      abort_q  <= abort_d;
      spiclk_q <= spiclk_d;
      spifr_q  <= spifr_d;
      oe_q     <= oe_d;
      ack_q    <= ack_d;
      sdi_q    <= SPIDAT;
    end
  end

  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    gap_d    = gap_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    rd_d     = rd_q;
    dat_o_d  = dat_o_q;
    we_d     = we_q;
    spiclk_d = spiclk_q;
    spifr_d  = spifr_q;
    oe_d     = oe_q;
    ack_d    = 1'b0;
    // A dropped cycle anywhere in the transfer only suppresses the ack; the frame still completes.
    abort_d  = abort_q | ((state_q != S_IDLE) & ~wb.wb_cyc_i);

    case (state_q)
      S_IDLE: begin
        if (wb.wb_cyc_i && wb.wb_stb_i) begin
          we_d    = wb.wb_we_i;
          sr_d    = {~wb.wb_we_i, wb.wb_adr_i, (wb.wb_we_i ? wb.wb_dat_i : 16'h0000)};
          rd_d    = '0;
          spifr_d = 1'b0;
          oe_d    = 1'b1;
          half_d  = '0;
          abort_d = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        half_d = half_q + 1'b1;
        if (POSTED && we_q && half_q == '0 && wb.wb_cyc_i && wb.wb_stb_i) ack_d = 1'b1;
        if (half_q == HALF_END) begin
          half_d   = '0;
          bit_d    = '0;
          spiclk_d = 1'b0;
          state_d  = S_CMD;
        end
      end
      S_CMD, S_WDATA, S_RDATA: begin
        half_d = half_q + 1'b1;
        if (half_q == HALF_END) begin
          half_d = '0;
          if (!spiclk_q) begin
            spiclk_d = 1'b1;
            if (state_q == S_RDATA) rd_d = {rd_q[14:0], sdi_q};
          end else if (bit_q == 5'd15) begin
            bit_d = '0;
            if (state_q == S_CMD && we_q) begin
              spiclk_d = 1'b0;
              sr_d     = {sr_q[30:0], 1'b0};
              state_d  = S_WDATA;
            end else if (state_q == S_CMD) begin
              oe_d    = 1'b0;
              gap_d   = '0;
              state_d = S_TURN;
            end else begin
              spifr_d = 1'b1;
              oe_d    = 1'b0;
              state_d = S_END;
            end
          end else begin
            bit_d    = bit_q + 5'd1;
            spiclk_d = 1'b0;
            sr_d     = {sr_q[30:0], 1'b0};
          end
        end
      end
      S_TURN: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_END) begin
          half_d   = '0;
          bit_d    = '0;
          spiclk_d = 1'b0;
          state_d  = S_RDATA;
        end
      end
      S_END: begin
        state_d = S_ACK;
        if (!abort_q && !(POSTED && we_q) && wb.wb_cyc_i && wb.wb_stb_i) begin
          ack_d = 1'b1;
          if (!we_q) dat_o_d = rd_q;
        end
      end
      S_ACK: begin
        gap_d   = '0;
        state_d = S_RECOVER;
      end
      S_RECOVER: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_END) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_wb_spimaster.sv
// Directed bench for wb_spimaster with a bit-level channel SPI slave model at stone 2 and a pulled-up SPIDAT.
module tb_wb_spimaster;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spiclk, spifr;
  tri1  spidat;

  wb_spimaster_if wb();

  wb_spimaster #(.CLKDIV(4), .TURN_GAP(112)) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .SPICLK (spiclk),
    .SPIDAT (spidat),
    .SPIFR  (spifr),
    .wb     (wb)
  );

  always #4 clk = ~clk;

`ifdef WSPI_POSTED_WRITE_EN
  localparam int WR_LAT = 2;
`else
  localparam int WR_LAT = 262;
`endif
  localparam int RD_LAT = 374;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Channel slave: samples on SPICLK rise, drives read data from SPICLK fall.
  localparam logic [1:0] STADDR = 2'd2;
  logic [31:0] s_sr = '0;
  logic [15:0] s_cmd = '0;
  logic [15:0] s_rdw = '0;
  int          s_cnt = 0;
  logic        s_oe = 1'b0, s_bit = 1'b0, s_probe = 1'b0;
  int          wr_cnt = 0;
  logic [12:0] wr_adr = '0;
  logic [15:0] wr_dat = '0;
  logic [31:0] last_frame = '0;
  int          last_cnt = 0;

  assign spidat = s_oe ? s_bit : (s_probe ? 1'b0 : 1'bz);

  always @(negedge spifr) begin
    s_cnt = 0;
    s_sr  = '0;
  end

  always @(posedge spiclk) begin
    if (!spifr && s_cnt < 32) begin
      s_sr = {s_sr[30:0], spidat};
      s_cnt++;
      if (s_cnt == 16) s_cmd = s_sr[15:0];
    end
  end

  always @(negedge spiclk) begin
    if (!spifr && s_cnt >= 16 && s_cnt < 32 && s_cmd[15] && s_cmd[14:13] == STADDR) begin
      s_oe  = 1'b1;
      s_bit = s_rdw[4'(31 - s_cnt)];
    end
  end

  always @(posedge spifr) begin
    s_oe       = 1'b0;
    last_frame = s_sr;
    last_cnt   = s_cnt;
    if (s_cnt == 32 && !s_cmd[15] && s_cmd[14:13] == STADDR) begin
      wr_cnt++;
      wr_adr = s_cmd[12:0];
      wr_dat = s_sr[15:0];
    end
  end

  int hi_run = 0, last_gap = 0;
  always @(negedge clk) begin
    if (spifr) hi_run++;
    else if (hi_run != 0) begin
      last_gap = hi_run;
      hi_run   = 0;
    end
  end

  task automatic wb_xfer(input logic [14:0] adr, input logic [15:0] dat, input logic we,
                         output logic [15:0] rdata, output int lat);
    @(negedge clk);
    wb.wb_adr_i = adr;
    wb.wb_dat_i = dat;
    wb.wb_we_i  = we;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    lat = 0;
    while (lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
      if (wb.wb_ack_o) break;
    end
    rdata = wb.wb_dat_o;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
  endtask

  task automatic settle();
    int w = 0;
    while (!spifr && w < 1000) begin
      @(negedge clk);
      w++;
    end
    repeat (130) @(negedge clk);
  endtask

  logic [15:0] rdata;
  int          lat, lat2, w, acks, wr_before;

  initial begin
    wb.wb_adr_i = '0;
    wb.wb_dat_i = '0;
    wb.wb_we_i  = 1'b0;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_spifr", spifr, 1);
    check("rst_spiclk", spiclk, 1);
    check("rst_spidat_released", spidat, 1);
    check("rst_ack", wb.wb_ack_o, 0);
    check("rst_dat_o", wb.wb_dat_o, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    wb_xfer(15'h4123, 16'hBEEF, 1'b1, rdata, lat);
    check("wr_latency", lat, WR_LAT);
    settle();
    check("wr_frame_bits", last_frame, 32'h4123BEEF);
    check("wr_frame_len", last_cnt, 32);
    check("wr_slave_count", wr_cnt, 1);
    check("wr_slave_adr", wr_adr, 13'h0123);
    check("wr_slave_dat", wr_dat, 16'hBEEF);

    s_rdw = 16'hA55A;
    fork
      wb_xfer(15'h5FFF, 16'h0000, 1'b0, rdata, lat);
      begin
        w = 0;
        while (s_cnt != 16 && w < 1000) begin
          @(posedge clk);
          w++;
        end
        check("rd_cmd_done_in_time", (w < 1000), 1);
        repeat (20) @(posedge clk);
        s_probe = 1'b1;
        @(negedge clk);
        check("rd_turn_released", spidat, 0);
        @(posedge clk);
        s_probe = 1'b0;
      end
    join
    check("rd_latency", lat, RD_LAT);
    check("rd_data", rdata, 16'hA55A);
    check("rd_frame_bits", last_frame, 32'hDFFFA55A);
    settle();

    wb_xfer(15'h2010, 16'h0000, 1'b0, rdata, lat);
    check("rd_stone1_latency", lat, RD_LAT);
    check("rd_stone1_data", rdata, 16'hFFFF);
    check("rd_stone1_frame", last_frame, 32'hA010FFFF);
    settle();

    wb_xfer(15'h4001, 16'h1234, 1'b1, rdata, lat);
    check("wr2_latency", lat, WR_LAT);
    settle();
    check("wr2_frame_bits", last_frame, 32'h40011234);

    wb_xfer(15'h4011, 16'h1111, 1'b1, rdata, lat);
    wb_xfer(15'h4022, 16'h2222, 1'b1, rdata, lat2);
    check("b2b_first_latency", lat, WR_LAT);
    check("b2b_second_latency", lat2, 375);
    check("b2b_spifr_gap", last_gap, 115);
    settle();
    check("b2b_slave_adr", wr_adr, 13'h0022);
    check("b2b_slave_dat", wr_dat, 16'h2222);

    wr_before = wr_cnt;
    @(negedge clk);
    wb.wb_adr_i = 15'h4005;
    wb.wb_dat_i = 16'h5555;
    wb.wb_we_i  = 1'b1;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    repeat (50) @(negedge clk);
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    acks = 0;
    repeat (500) begin
      @(negedge clk);
      if (wb.wb_ack_o) acks++;
    end
    check("cycdrop_no_ack", acks, 0);
    check("cycdrop_frame_done", wr_cnt, wr_before + 1);
    check("cycdrop_slave_dat", wr_dat, 16'h5555);

    wr_before = wr_cnt;
    @(negedge clk);
    wb.wb_adr_i = 15'h4123;
    wb.wb_dat_i = 16'h0000;
    wb.wb_we_i  = 1'b1;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    w = 0;
    while (s_cnt != 20 && w < 1000) begin
      @(posedge clk);
      w++;
    end
    check("rstmid_bit20_reached", (w < 1000), 1);
    #1;
    check("rstmid_bit_driven_low", spidat, 0);
    rst_n = 1'b0;
    #1;
    check("rstmid_spifr", spifr, 1);
    check("rstmid_spiclk", spiclk, 1);
    check("rstmid_spidat_released", spidat, 1);
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (wb.wb_ack_o) acks++;
    end
    check("rstmid_no_ack", acks, 0);
    check("rstmid_no_slave_write", wr_cnt, wr_before);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    wb_xfer(15'h4123, 16'hBEEF, 1'b1, rdata, lat);
    check("post_rst_wr_latency", lat, WR_LAT);
    settle();
    check("post_rst_frame", last_frame, 32'h4123BEEF);
    check("post_rst_slave_write", wr_cnt, wr_before + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
